// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: loads a parallel pattern over valid/ready and shifts it out MSB-of-frame first,
// repeating it a programmed number of times (0 = until abort).
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic             abort_i,
    output logic             data_out_o,
    output logic             bit_valid_o,
    output logic             frame_start_o,
    output logic             done_o
);
    // Pattern is held zero-extended to 2**LEN_W bits so any index value selects a real bit.
    localparam int PW = 1 << LEN_W;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    pat_q, pat_d, pat_in;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, len_c;
    logic [CNT_W-1:0] rep_q, rep_d, cnt_q, cnt_d;
    logic             data_q, data_d, valid_q, valid_d, fs_q, fs_d, done_q, done_d, ready_q, ready_d;

    assign pat_in = PW'(pattern_i);
    assign len_c  = (len_i == '0 || len_i > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_i;

    assign load_ready_o  = ready_q;
    assign data_out_o    = data_q;
    assign bit_valid_o   = valid_q;
    assign frame_start_o = fs_q;
    assign done_o        = done_q;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = 1'b0;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (load_valid_i && ready_q) begin
                    state_d = SHIFT;
                    pat_d   = pat_in;
                    len_d   = len_c;
                    rep_d   = repeat_i;
                    cnt_d   = repeat_i;
                    idx_d   = len_c - 1'b1;
                    data_d  = pat_in[len_c - 1'b1];
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                    ready_d = 1'b0;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - 1'b1;
                    data_d  = pat_q[idx_q - 1'b1];
                    valid_d = 1'b1;
                end else if (rep_q == '0 || cnt_q > CNT_W'(1)) begin
                    cnt_d   = (rep_q == '0) ? cnt_q : cnt_q - 1'b1;
                    idx_d   = len_q - 1'b1;
                    data_d  = pat_q[len_q - 1'b1];
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx; expected bits are queued at load
// and popped by a monitor on every bit_valid cycle.
module tb_seq_pattern_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid_i = 1'b0;
    logic       load_ready_o;
    logic [7:0] pattern_i = '0;
    logic [3:0] len_i = '0;
    logic [3:0] repeat_i = '0;
    logic       abort_i = 1'b0;
    logic       data_out_o, bit_valid_o, frame_start_o, done_o;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [1:0] exp_q[$];
    logic [2:0] hist = '0;
    int         nb = 0;
    int         det = 0;

    seq_pattern_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .pattern_i    (pattern_i),
        .len_i        (len_i),
        .repeat_i     (repeat_i),
        .abort_i      (abort_i),
        .data_out_o   (data_out_o),
        .bit_valid_o  (bit_valid_o),
        .frame_start_o(frame_start_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Queue the first nbits of the repeating frame stream: {bit, frame_start}.
    task automatic push_exp(input logic [7:0] pat, input logic [3:0] len, input int nbits);
        int l;
        l = (len == 0 || len > 8) ? 8 : int'(len);
        for (int k = 0; k < nbits; k++) begin
            int i;
            i = l - 1 - (k % l);
            exp_q.push_back({pat[i], (k % l) == 0});
        end
    endtask

    // Entered at a negedge; returns at the negedge where the first bit is visible.
    task automatic start(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep,
                         input int nbits, input bit hold);
        int t = 0;
        while (!load_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", load_ready_o, 1);
        pattern_i    = pat;
        len_i        = len;
        repeat_i     = rep;
        load_valid_i = 1'b1;
        push_exp(pat, len, nbits);
        @(negedge clk);
        if (!hold) load_valid_i = 1'b0;
    endtask

    task automatic expect_run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, bit_valid_o, 1);
            chk({tag, "_nodone"}, done_o, 0);
            @(negedge clk);
        end
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_endvalid"}, bit_valid_o, 0);
        chk({tag, "_ready_low"}, load_ready_o, 0);
        @(negedge clk);
        chk({tag, "_done_one"}, done_o, 0);
        chk({tag, "_ready"}, load_ready_o, 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial forever begin
        logic [1:0] e;
        @(negedge clk);
        if (bit_valid_o) begin
            if (exp_q.size() == 0) chk("unexpected_bit", bit_valid_o, 0);
            else begin
                e = exp_q.pop_front();
                chk("data", data_out_o, e[1]);
                chk("fstart", frame_start_o, e[0]);
            end
            hist = {hist[1:0], data_out_o};
            nb++;
            if (nb >= 3 && hist == 3'b110) det++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", load_ready_o, 1);
        chk("rst_data", data_out_o, 0);
        chk("rst_valid", bit_valid_o, 0);
        chk("rst_fs", frame_start_o, 0);
        chk("rst_done", done_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start(8'b0000_0110, 3, 2, 6, 0);
        expect_run("basic", 6);

        start(8'hA5, 0, 1, 8, 0);
        expect_run("len0", 8);
        start(8'h3C, 12, 1, 8, 0);
        expect_run("len12", 8);
        start(8'h01, 1, 3, 3, 0);
        expect_run("len1", 3);

        start(8'b110, 3, 0, 14, 0);
        repeat (13) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_valid", bit_valid_o, 0);
        chk("abort_done", done_o, 1);
        @(negedge clk);
        chk("abort_done_one", done_o, 0);
        chk("abort_ready", load_ready_o, 1);
        chk("abort_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("abort_quiet", bit_valid_o, 0);

        abort_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_abort_done", done_o, 0);
            chk("idle_abort_ready", load_ready_o, 1);
        end
        abort_i = 1'b0;

        start(8'hF0, 8, 1, 8, 1);
        pattern_i = 8'h0F;
        len_i     = 4;
        repeat_i  = 3;
        expect_run("hold_a", 8);
        push_exp(8'h0F, 4, 12);
        @(negedge clk);
        load_valid_i = 1'b0;
        expect_run("hold_b", 12);

        start(8'b110, 3, 0, 9, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", load_ready_o, 1);
        chk("arst_data", data_out_o, 0);
        chk("arst_valid", bit_valid_o, 0);
        chk("arst_fs", frame_start_o, 0);
        chk("arst_done", done_o, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        nb = 0;
        det = 0;
        hist = '0;
        start(8'b110, 3, 4, 12, 0);
        expect_run("loop110", 12);
        chk("loop110_det", det, 4);
        nb = 0;
        det = 0;
        hist = '0;
        start(8'b101, 3, 4, 12, 0);
        expect_run("loop101", 12);
        chk("loop101_det", det, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
